// File: rtl/mmio_console_if.sv
// CPU data-memory bus as seen by the console device: one read port and one write port.
// The master side issues requests, and the slave side returns read data and write acceptance.
interface mmio_console_if;
   logic        dmem_rready;
   logic [31:0] dmem_raddr;
   logic [31:0] dmem_rdata;
   logic        dmem_rvalid;
   logic        dmem_wready;
   logic [31:0] dmem_waddr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_wvalid;

   modport master (
      output dmem_rready, dmem_raddr, dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb,
      input  dmem_rdata, dmem_rvalid, dmem_wvalid
   );

   modport slave (
      input  dmem_rready, dmem_raddr, dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb,
      output dmem_rdata, dmem_rvalid, dmem_wvalid
   );
endinterface

// File: rtl/mmio_console.sv
// Memory-mapped console: PUTC/GETC/STATUS/EXIT words in the I/O page, TX FIFO to a byte sink,
// RX FIFO from a byte source, sticky exit flag with the first exit code.
module mmio_console #(
   parameter logic [31:0] BASE  = 32'h8000_0000,
   parameter int          DEPTH = 16
) (
   input  logic                clk,
   input  logic                resetb,
   mmio_console_if.slave       bus,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic [7:0]          tx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   input  logic [7:0]          rx_data,
   output logic                exit,
   output logic [31:0]         exit_code
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   localparam logic [7:0] OFF_PUTC   = 8'h1c;
   localparam logic [7:0] OFF_GETC   = 8'h20;
   localparam logic [7:0] OFF_STATUS = 8'h24;
   localparam logic [7:0] OFF_EXIT   = 8'h2c;

   logic [7:0]    txMem_q [DEPTH];
   logic [7:0]    rxMem_q [DEPTH];
   logic [AW-1:0] txHead_q, txHead_d, txTail_q, txTail_d;
   logic [AW-1:0] rxHead_q, rxHead_d, rxTail_q, rxTail_d;
   logic [CW-1:0] txCount_q, txCount_d, rxCount_q, rxCount_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          alive_q;
   logic          exit_q;
   logic [31:0]   exitCode_q;

   logic rdHit, wrHit, putcReq, getcReq, exitWr;
   logic txFull, txEmpty, rxFull, rxEmpty;
   logic txPush, txPop, rxPush, rxPop;

   assign rdHit   = bus.dmem_raddr[31:8] == BASE[31:8];
   assign wrHit   = bus.dmem_waddr[31:8] == BASE[31:8];
   assign putcReq = bus.dmem_wready && wrHit && (bus.dmem_waddr[7:0] == OFF_PUTC) && bus.dmem_wstrb[0];
   assign getcReq = bus.dmem_rready && rdHit && (bus.dmem_raddr[7:0] == OFF_GETC);
   assign exitWr  = bus.dmem_wready && wrHit && (bus.dmem_waddr[7:0] == OFF_EXIT)
                    && (|bus.dmem_wstrb) && !exit_q;

   assign txFull  = txCount_q == FULL_COUNT;
   assign txEmpty = txCount_q == '0;
   assign rxFull  = rxCount_q == FULL_COUNT;
   assign rxEmpty = rxCount_q == '0;

   // A full TX FIFO refuses the push even if the sink frees a slot this same cycle.
   assign txPush = putcReq && !txFull;
   assign txPop  = tx_valid && tx_ready;
   assign rxPush = rx_valid && rx_ready;
   assign rxPop  = getcReq && !rxEmpty;

   assign bus.dmem_wvalid = !(putcReq && txFull);
   assign bus.dmem_rvalid = alive_q;
   assign bus.dmem_rdata  = rdata_q;
   assign tx_valid        = !txEmpty;
   assign tx_data         = txEmpty ? 8'h00 : txMem_q[txHead_q];
   assign rx_ready        = alive_q && !rxFull;
   assign exit            = exit_q;
   assign exit_code       = exitCode_q;

   always_comb begin
      rdata_d = rdata_q;
      if (bus.dmem_rready) begin
         rdata_d = 32'h0;
         if (rdHit) begin
            case (bus.dmem_raddr[7:0])
               OFF_GETC:   rdata_d = rxEmpty ? 32'hFFFF_FFFF : {24'h0, rxMem_q[rxHead_q]};
               OFF_STATUS: rdata_d = {8'h00, 8'(txCount_q), 8'(rxCount_q), 5'b0, rxEmpty, txEmpty, txFull};
               default:    rdata_d = 32'h0;
            endcase
         end
      end
   end

   always_comb begin
      txHead_d  = txPop  ? txHead_q + AW'(1) : txHead_q;
      txTail_d  = txPush ? txTail_q + AW'(1) : txTail_q;
      rxHead_d  = rxPop  ? rxHead_q + AW'(1) : rxHead_q;
      rxTail_d  = rxPush ? rxTail_q + AW'(1) : rxTail_q;
      txCount_d = txCount_q;
      rxCount_d = rxCount_q;
      case ({txPush, txPop})
         2'b10:   txCount_d = txCount_q + CW'(1);
         2'b01:   txCount_d = txCount_q - CW'(1);
         default: txCount_d = txCount_q;
      endcase
      case ({rxPush, rxPop})
         2'b10:   rxCount_d = rxCount_q + CW'(1);
         2'b01:   rxCount_d = rxCount_q - CW'(1);
         default: rxCount_d = rxCount_q;
      endcase
   end

   // alive_q marks the first clock after reset release; it gates rvalid and rx_ready.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         alive_q    <= 1'b0;
         rdata_q    <= 32'h0;
         txHead_q   <= '0;
         txTail_q   <= '0;
         rxHead_q   <= '0;
         rxTail_q   <= '0;
         txCount_q  <= '0;
         rxCount_q  <= '0;
         exit_q     <= 1'b0;
         exitCode_q <= 32'h0;
      end else begin
         alive_q   <= 1'b1;
         rdata_q   <= rdata_d;
         txHead_q  <= txHead_d;
         txTail_q  <= txTail_d;
         rxHead_q  <= rxHead_d;
         rxTail_q  <= rxTail_d;
         txCount_q <= txCount_d;
         rxCount_q <= rxCount_d;
         if (exitWr) begin
            exit_q     <= 1'b1;
            exitCode_q <= bus.dmem_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (txPush) txMem_q[txTail_q] <= bus.dmem_wdata[7:0];
      if (rxPush) rxMem_q[rxTail_q] <= rx_data;
   end

endmodule
